mem_rw_arbiter: RTL
===================

// Module: mem_rw_arbiter
// PURPOSE
//  Shares the single read/write port of main memory among NREQ requesters
//  (CPU load/store, console loader, debug port).
//  Holds off all traffic while memory runs its post-reset wipe sweep.
//  Arbitrates round-robin, with an optional per-requester lock for read-modify-write.
//  Routes each memory response back to the requester that issued the transaction.
// PARAMETERS
//  NREQ        3    number of requesters (2..8)
//  AW          8    address width (256 words)
//  DW          16   data width
//  INIT_CYCLES 256  cycles of memory wipe after reset during which no grant is given
//  READ_LAT    1    memory port latency, accept -> rdata valid (1..3)
// PORTS
//  clk_i        in   1        clock
//  rst_ni       in   1        asynchronous, active-high reset
//  req_val_i    in   NREQ     per-requester transaction valid
//  req_wen_i    in   NREQ     1=write, 0=read
//  req_lock_i   in   NREQ     keep grant on this requester after its accept
//  req_addr_i   in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  req_wdata_i  in   NREQ*DW  packed write data
//  req_rdy_o    out  NREQ     one-hot-or-zero grant; accept = val & rdy
//  rsp_val_o    out  NREQ     one-hot completion strobe
//  rsp_rdata_o  out  DW       read data, qualified by rsp_val_o
//  mem_val_o    out  1        memory port enable
//  mem_wen_o    out  1        memory write enable
//  mem_addr_o   out  AW       memory address
//  mem_wdata_o  out  DW       memory write data
//  mem_rdata_i  in   DW       memory read data, READ_LAT after mem_val_o
//  busy_o       out  1        high during INIT
// BEHAVIOUR
//  - Reset: state=INIT, init counter=0, rr pointer=NREQ-1.
//    Response pipe cleared.
//    All outputs 0 except busy_o=1.
//  - INIT: req_rdy_o=0 and mem_val_o=0.
//    Counter increments every cycle.
//    At count INIT_CYCLES-1 -> RUN next cycle; busy_o drops with the transition.
//  - RUN grant (combinational from req_val_i and pointer):
//    - If lock is held by owner L and req_val_i[L]=1: grant L only.
//    - Otherwise grant the first valid index scanning ptr+1, ptr+2, ... modulo NREQ.
//    - req_rdy_o is never asserted without req_val_i on that bit.
//  - Accept cycle: mem_val_o=1 with wen/addr/wdata of the winner, same cycle (no register).
//    Pointer <= winner.
//    If req_lock_i[winner]=1, lock owner <= winner.
//  - Lock release: lock owner releases when its req_lock_i is low at an accept, or when its req_val_i is low.
//    In either case, normal round-robin applies that cycle.
//  - Response: every accept (read or write) pushes {id, wen} into a READ_LAT-deep shift pipe.
//    At the output: rsp_val_o[id]=1 and rsp_rdata_o=mem_rdata_i, or 0 for a write.
//    One accept per cycle gives full throughput; no back-pressure on responses.
//  - Ordering: responses return in accept order.
//    A write followed by a read to the same address returns the new data.
//  - A requester may drop req_val_i without an accept; nothing is issued for it.
//  - Reset mid-operation: the pipe is flushed and in-flight responses are lost.
//    The block re-enters INIT for a full sweep.
//  - No grant is given before the counter completes, including when INIT_CYCLES=1.
// STRUCTURE
//  - mem_arb_pkg holds:
//    - typedef enum logic {ST_INIT, ST_RUN} arb_state_t
//    - default AW/DW localparams
//    - rsp_tag_t struct {id, wen}
//  - Sub-module rr_pick: NREQ-bit request plus pointer in, one-hot grant and valid out.
//    Purely combinational.
//  - Top level holds the FSM, init counter, lock owner, response shift pipe and mux.
// TESTING
//  1. Reset, then requester 0 holds val.
//     -> rdy 0 for 256 cycles, first accept at cycle 256, busy_o falls at 256.
//  2. Writes after INIT: req0 writes addr 0x10 = 0xBEEF, then req1 reads 0x10.
//     -> rsp_val_o=001 and then 010, rsp_rdata_o=0xBEEF one cycle after the read accept.
//  3. All 3 requesters hold val continuously.
//     -> grants rotate 0,1,2,0,... with one accept every cycle and no starvation.
//  4. req1 issues 4 accepts with lock=1 while req0 and req2 are valid.
//     -> req1 gets 4 back-to-back grants; after lock drops the next grant goes to req2.
//  5. Reset pulsed one cycle after a read accept.
//     -> no rsp_val_o, outputs 0, and a full 256-cycle INIT restarts.
//  6. Sweep READ_LAT=3 with a random mix.
//     -> scoreboard matches data and ids in order, and rsp_val_o is always one-hot.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory read/write port arbiter.
package mem_arb_pkg;

  typedef enum logic {ST_INIT, ST_RUN} arb_state_t;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 16;
  localparam int unsigned ID_W   = 3;

  // One response pipe slot; vld marks a real accept in this stage.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            wen;
  } rsp_tag_t;

endpackage

// File: rtl/mem_rw_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning ptr+1, ptr+2, ... modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            vld_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(ptr_i) + i) % NREQ);
      if (!vld_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        vld_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rw_arbiter.sv
// Shares one memory port among NREQ requesters: post-reset wipe hold-off,
// round-robin grant with optional lock, and in-order response routing.
module mem_rw_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned INIT_CYCLES = 256,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_val_i,
  input  logic [NREQ-1:0]    req_wen_i,
  input  logic [NREQ-1:0]    req_lock_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]    req_rdy_o,
  output logic [NREQ-1:0]    rsp_val_o,
  output logic [DW-1:0]      rsp_rdata_o,
  output logic               mem_val_o,
  output logic               mem_wen_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [DW-1:0]      mem_wdata_o,
  input  logic [DW-1:0]      mem_rdata_i,
  output logic               busy_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  arb_state_t     state_q;
  logic [CW-1:0]  init_cnt_q;
  logic [IW-1:0]  ptr_q;
  logic           lock_vld_q;
  logic [IW-1:0]  lock_own_q;
  logic           busy_q;
  rsp_tag_t       pipe_q [READ_LAT];

  logic [NREQ-1:0] rr_gnt;
  logic [IW-1:0]   rr_idx;
  logic            rr_vld;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   win;
  logic            accept;
  logic            lock_hit;
  rsp_tag_t        tag_out;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i (req_val_i),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .vld_o (rr_vld)
  );

  assign lock_hit = lock_vld_q && req_val_i[lock_own_q];

  always_comb begin
    gnt = '0;
    win = '0;
    if (state_q == ST_RUN) begin
      if (lock_hit) begin
        gnt[lock_own_q] = 1'b1;
        win             = lock_own_q;
      end else if (rr_vld) begin
        gnt = rr_gnt;
        win = rr_idx;
      end
    end
  end

  assign accept      = |gnt;
  assign req_rdy_o   = gnt;
  assign mem_val_o   = accept;
  assign mem_wen_o   = accept && req_wen_i[win];
  assign mem_addr_o  = accept ? req_addr_i[win*AW +: AW]  : '0;
  assign mem_wdata_o = accept ? req_wdata_i[win*DW +: DW] : '0;
  assign busy_o      = busy_q;

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ptr_q      <= IW'(NREQ - 1);
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
      busy_q     <= 1'b1;
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == CW'(INIT_CYCLES - 1)) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Lock is re-decided at every accept; an idle owner loses it.
          if (accept) begin
            ptr_q      <= win;
            lock_vld_q <= req_lock_i[win];
            lock_own_q <= win;
          end else if (lock_vld_q && !req_val_i[lock_own_q]) begin
            lock_vld_q <= 1'b0;
          end
        end
      endcase

      pipe_q[0] <= '{vld: accept, id: ID_W'(win), wen: req_wen_i[win]};
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_out = pipe_q[READ_LAT-1];

  always_comb begin
    rsp_val_o = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp_val_o[i] = tag_out.vld && (tag_out.id == ID_W'(i));
    end
  end

  assign rsp_rdata_o = (tag_out.vld && !tag_out.wen) ? mem_rdata_i : '0;

endmodule
